// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - draws unique cards from a 52-card deck using rejection sampling
// Optional reject counter compiled in with CARD_DEALER_REJECT_CNT_EN.
module card_dealer #(
    parameter int HAND_SIZE = 5
) (
    input  logic       clk_i,
    input  logic       clr_n_i,
    input  logic       deal_i,
    input  logic       new_deck_i,
    input  logic [5:0] rnd_i,
    input  logic       rnd_valid_i,
    output logic       rnd_ready_o,
    output logic       card_valid_o,
    output logic [3:0] card_rank_o,
    output logic [1:0] card_suit_o,
    output logic [5:0] dealt_cnt_o,
    output logic       hand_done_o,
    output logic       deck_empty_o,
    output logic [7:0] reject_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    localparam logic [5:0] HAND_LAST = 6'(HAND_SIZE - 1);

    state_t      state_q, state_d;
    logic [5:0]  cand_q, cand_d;
    logic [51:0] mask_q, mask_d;
    logic [3:0]  card_rank_q, card_rank_d;
    logic [1:0]  card_suit_q, card_suit_d;
    logic [5:0]  dealt_cnt_q, dealt_cnt_d;
    logic [5:0]  hand_cnt_q, hand_cnt_d;
    logic        card_valid_q, card_valid_d;
    logic        hand_done_q, hand_done_d;
    logic        deck_empty_q, deck_empty_d;

    logic [63:0] mask_ext;
    logic        cand_taken;
    logic [1:0]  cand_suit;
    logic [5:0]  cand_base;

    // Out-of-range candidates look like already-dealt cards, so one lookup covers both rejects.
    assign mask_ext   = {12'hFFF, mask_q};
    assign cand_taken = mask_ext[cand_q];

    always_comb begin
        cand_suit = 2'd3;
        cand_base = 6'd39;
        if (cand_q < 6'd13) begin
            cand_suit = 2'd0;
            cand_base = 6'd0;
        end else if (cand_q < 6'd26) begin
            cand_suit = 2'd1;
            cand_base = 6'd13;
        end else if (cand_q < 6'd39) begin
            cand_suit = 2'd2;
            cand_base = 6'd26;
        end
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        mask_d       = mask_q;
        card_rank_d  = card_rank_q;
        card_suit_d  = card_suit_q;
        dealt_cnt_d  = dealt_cnt_q;
        hand_cnt_d   = hand_cnt_q;
        deck_empty_d = deck_empty_q;
        card_valid_d = 1'b0;
        hand_done_d  = 1'b0;
        rnd_ready_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (deal_i && !deck_empty_q) begin
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                rnd_ready_o = 1'b1;
                if (rnd_valid_i) begin
                    cand_d  = rnd_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cand_taken) begin
                    state_d = S_DRAW;
                end else begin
                    mask_d       = mask_q | (52'd1 << cand_q);
                    card_suit_d  = cand_suit;
                    card_rank_d  = 4'(cand_q - cand_base) + 4'd1;
                    dealt_cnt_d  = dealt_cnt_q + 6'd1;
                    deck_empty_d = (dealt_cnt_q == 6'd51);
                    card_valid_d = 1'b1;
                    if (hand_cnt_q == HAND_LAST) begin
                        hand_cnt_d  = 6'd0;
                        hand_done_d = 1'b1;
                    end else begin
                        hand_cnt_d = hand_cnt_q + 6'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh deck overrides whatever the FSM decided; rank/suit deliberately survive.
        if (new_deck_i) begin
            state_d      = S_IDLE;
            mask_d       = '0;
            dealt_cnt_d  = '0;
            hand_cnt_d   = '0;
            deck_empty_d = 1'b0;
            card_valid_d = 1'b0;
            hand_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q      <= S_IDLE;
            cand_q       <= '0;
            mask_q       <= '0;
            card_rank_q  <= '0;
            card_suit_q  <= '0;
            dealt_cnt_q  <= '0;
            hand_cnt_q   <= '0;
            card_valid_q <= 1'b0;
            hand_done_q  <= 1'b0;
            deck_empty_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            mask_q       <= mask_d;
            card_rank_q  <= card_rank_d;
            card_suit_q  <= card_suit_d;
            dealt_cnt_q  <= dealt_cnt_d;
            hand_cnt_q   <= hand_cnt_d;
            card_valid_q <= card_valid_d;
            hand_done_q  <= hand_done_d;
            deck_empty_q <= deck_empty_d;
        end
    end

`ifdef CARD_DEALER_REJECT_CNT_EN
    logic [7:0] reject_cnt_q;
    logic       rejected;

    assign rejected = (state_q == S_CHECK) && cand_taken;

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            reject_cnt_q <= '0;
        end else if (new_deck_i) begin
            reject_cnt_q <= '0;
        end else if (rejected && (reject_cnt_q != 8'hFF)) begin
            reject_cnt_q <= reject_cnt_q + 8'd1;
        end
    end

    assign reject_cnt_o = reject_cnt_q;
`else
    assign reject_cnt_o = '0;
`endif

    assign card_valid_o = card_valid_q;
    assign card_rank_o  = card_rank_q;
    assign card_suit_o  = card_suit_q;
    assign dealt_cnt_o  = dealt_cnt_q;
    assign hand_done_o  = hand_done_q;
    assign deck_empty_o = deck_empty_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - scoreboard bench for card_dealer with a deck-level reference model
module tb_card_dealer;

    localparam int HS = 5;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       deal = 1'b0;
    logic       new_deck = 1'b0;
    logic [5:0] rnd = '0;
    logic       rnd_valid = 1'b0;
    logic       rnd_ready;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic [5:0] dealt_cnt;
    logic       hand_done;
    logic       deck_empty;
    logic [7:0] reject_cnt;

    card_dealer #(.HAND_SIZE(HS)) dut (
        .clk_i        (clk),
        .clr_n_i      (clr_n),
        .deal_i       (deal),
        .new_deck_i   (new_deck),
        .rnd_i        (rnd),
        .rnd_valid_i  (rnd_valid),
        .rnd_ready_o  (rnd_ready),
        .card_valid_o (card_valid),
        .card_rank_o  (card_rank),
        .card_suit_o  (card_suit),
        .dealt_cnt_o  (dealt_cnt),
        .hand_done_o  (hand_done),
        .deck_empty_o (deck_empty),
        .reject_cnt_o (reject_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int rank;
        int suit;
        int cnt;
        int hd;
        int emp;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the deck as a set of dealt cards plus plain counters.
    bit m_dealt[52];
    int m_cnt  = 0;
    int m_hand = 0;
    int m_rej  = 0;

    function automatic void model_clear();
        foreach (m_dealt[i]) m_dealt[i] = 1'b0;
        m_cnt  = 0;
        m_hand = 0;
        m_rej  = 0;
    endfunction

    function automatic bit model_takes(input int v);
        if (v >= 52) return 1'b0;
        return !m_dealt[v];
    endfunction

    function automatic int exp_rej();
`ifdef CARD_DEALER_REJECT_CNT_EN
        return m_rej;
`else
        return 0;
`endif
    endfunction

    function automatic void model_cand(input int v);
        exp_t e;
        if (!model_takes(v)) begin
            if (m_rej < 255) m_rej++;
        end else begin
            m_dealt[v] = 1'b1;
            m_cnt++;
            m_hand = (m_hand + 1) % HS;
            e.rank = v % 13 + 1;
            e.suit = v / 13;
            e.cnt  = m_cnt;
            e.hd   = (m_hand == 0) ? 1 : 0;
            e.emp  = (m_cnt == 52) ? 1 : 0;
            exp_q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (clr_n && card_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_card_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("card_rank", int'(card_rank), e.rank);
                chk("card_suit", int'(card_suit), e.suit);
                chk("dealt_cnt", int'(dealt_cnt), e.cnt);
                chk("hand_done", int'(hand_done), e.hd);
                chk("deck_empty", int'(deck_empty), e.emp);
            end
        end else if (clr_n && hand_done) begin
            chk("hand_done_without_card", 1, 0);
        end
    end

    int seq[$];

    // Entered #1 after a rising edge with the DUT idle; seq must end in an accepted card.
    task automatic deal_list();
        int start;
        int tmo;
        int lat;
        deal  = 1'b1;
        start = cyc;
        @(posedge clk); #1;
        deal = 1'b0;
        foreach (seq[i]) begin
            rnd       = 6'(seq[i]);
            rnd_valid = 1'b1;
            tmo = 0;
            while (!rnd_ready && tmo < 20) begin
                @(posedge clk); #1;
                tmo++;
            end
            if (!rnd_ready) begin
                chk("rnd_ready_timeout", 0, 1);
                rnd_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            rnd_valid = 1'b0;
            model_cand(seq[i]);
        end
        tmo = 0;
        while (!card_valid && tmo < 20) begin
            @(posedge clk); #1;
            tmo++;
        end
        lat = cyc - start;
        chk("card_valid_seen", int'(card_valid), 1);
        chk("latency", lat, 3 + 2 * (seq.size() - 1));
        chk("reject_cnt", int'(reject_cnt), exp_rej());
    endtask

    task automatic deal_one(input int v);
        seq = {v};
        deal_list();
    endtask

    task automatic do_new_deck();
        new_deck = 1'b1;
        @(posedge clk); #1;
        new_deck = 1'b0;
        model_clear();
        chk("nd_dealt_cnt", int'(dealt_cnt), 0);
        chk("nd_deck_empty", int'(deck_empty), 0);
        chk("nd_reject_cnt", int'(reject_cnt), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int tries;

        #12;
        chk("rst_rnd_ready", int'(rnd_ready), 0);
        chk("rst_card_valid", int'(card_valid), 0);
        chk("rst_card_rank", int'(card_rank), 0);
        chk("rst_card_suit", int'(card_suit), 0);
        chk("rst_dealt_cnt", int'(dealt_cnt), 0);
        chk("rst_deck_empty", int'(deck_empty), 0);
        chk("rst_reject_cnt", int'(reject_cnt), 0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk); #1;

        // Directed boundary cards.
        deal_one(0);
        deal_one(51);
        deal_one(25);
        deal_one(26);

        // Duplicate and out-of-range rejection.
        deal_one(7);
        seq = {7, 60, 63, 8};
        deal_list();

        // Hand boundaries with a fresh deck, then exhaust it.
        do_new_deck();
        for (int i = 0; i < 52; i++) deal_one(i);
        chk("full_deck_empty", int'(deck_empty), 1);
        chk("full_dealt_cnt", int'(dealt_cnt), 52);

        deal      = 1'b1;
        rnd       = 6'd0;
        rnd_valid = 1'b1;
        @(posedge clk); #1;
        deal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("empty_no_ready", int'(rnd_ready), 0);
            @(posedge clk); #1;
        end
        rnd_valid = 1'b0;

        do_new_deck();
        deal_one(0);

        // Randomized dealing against the model.
        do_new_deck();
        for (int n = 0; n < 30; n++) begin
            seq.delete();
            tries = 0;
            do begin
                v = int'($urandom_range(63, 0));
                tries++;
                if (tries > 60) begin
                    for (int k = 51; k >= 0; k--) if (!m_dealt[k]) v = k;
                end
                seq.push_back(v);
            end while (!model_takes(v));
            deal_list();
        end

        // new_deck while the candidate is being checked.
        do_new_deck();
        deal      = 1'b1;
        @(posedge clk); #1;
        deal      = 1'b0;
        rnd       = 6'd5;
        rnd_valid = 1'b1;
        chk("nd_check_draw_ready", int'(rnd_ready), 1);
        @(posedge clk); #1;
        rnd_valid = 1'b0;
        new_deck  = 1'b1;
        @(posedge clk); #1;
        new_deck  = 1'b0;
        chk("nd_check_ready", int'(rnd_ready), 0);
        chk("nd_check_dealt", int'(dealt_cnt), 0);
        @(posedge clk); #1;
        chk("nd_check_idle", int'(rnd_ready), 0);
        chk("nd_check_dealt2", int'(dealt_cnt), 0);

        // Asynchronous reset in the middle of a draw.
        deal_one(20);
        deal = 1'b1;
        @(posedge clk); #1;
        deal = 1'b0;
        chk("pre_rst_draw_ready", int'(rnd_ready), 1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst_rnd_ready", int'(rnd_ready), 0);
        chk("arst_card_valid", int'(card_valid), 0);
        chk("arst_card_rank", int'(card_rank), 0);
        chk("arst_card_suit", int'(card_suit), 0);
        chk("arst_dealt_cnt", int'(dealt_cnt), 0);
        chk("arst_hand_done", int'(hand_done), 0);
        chk("arst_deck_empty", int'(deck_empty), 0);
        chk("arst_reject_cnt", int'(reject_cnt), 0);
        model_clear();
        @(posedge clk); #1;
        clr_n = 1'b1;
        @(posedge clk); #1;
        deal_one(0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
